mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between instruction fetch (IF) and

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/arb_grant_sel.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the unified-memory port arbiter.
package riscv_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  // Which requester owns the current access
  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_e;

  // Bits needed to hold a counter value in [0, max_val]
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_grant_sel.sv
// Winner selection between fetch and data requests, with a starvation guard
// that forces a fetch grant after STARVE_MAX consecutive data grants.
module arb_grant_sel
  import riscv_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   if_req,
  input  logic   dm_req,
  input  logic   grant_en,
  output grant_e winner_c
);

  localparam int unsigned SW = cnt_width(STARVE_MAX);

  logic [SW-1:0] starve_cnt;
  logic          starved_c;

  // Data side wins unless the fetch side has been passed over too often
  always_comb begin
    starved_c = (starve_cnt == SW'(STARVE_MAX));
    winner_c  = GNT_IF;
    if (dm_req && !(if_req && starved_c)) begin
      winner_c = GNT_DM;
    end
  end

  // Count data grants that bypass a waiting fetch; saturates at the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_en) begin
      if (winner_c == GNT_DM && if_req) begin
        if (!starved_c) begin
          starve_cnt <= starve_cnt + SW'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port fixed-latency memory between instruction fetch and
// load/store access. Each access runs IDLE -> ISSUE -> WAIT -> DONE.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int unsigned CNT_W = cnt_width(MEM_LAT);

  arb_state_e       state;
  grant_e           grant;
  grant_e           winner_c;
  logic             grant_en_c;
  logic             acc_we;
  logic [CNT_W-1:0] cnt;

  // Requests are only arbitrated while the port is idle
  assign grant_en_c = (state == ARB_IDLE) && (if_req || dm_req);

  // Requester is held off until its completion pulse
  assign stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);

  arb_grant_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_sel (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .dm_req   (dm_req),
    .grant_en (grant_en_c),
    .winner_c (winner_c)
  );

  // Access sequencer, latency counter and memory/response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      grant     <= GNT_IF;
      acc_we    <= 1'b0;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_en_c) begin
            grant  <= winner_c;
            mem_en <= 1'b1;
            if (winner_c == GNT_DM) begin
              acc_we    <= dm_we;
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              acc_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
            state <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          cnt   <= CNT_W'(MEM_LAT - 1);
          state <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (cnt == '0) begin
            if (!acc_we) begin
              if (grant == GNT_DM) begin
                dm_rdata <= mem_rdata;
              end else begin
                if_rdata <= mem_rdata;
              end
            end
            if (grant == GNT_DM) begin
              dm_valid <= 1'b1;
            end else begin
              if_valid <= 1'b1;
            end
            state <= ARB_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ARB_DONE: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 2 and 1) driven by
// directed scenarios and randomized requesters, checked every cycle against a
// transaction-timeline model and a behavioural memory.
module tb_mem_port_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SMAX  = 4;
  localparam int unsigned NI    = 2;
  localparam int unsigned WORDS = 64;
  localparam int unsigned LAT0  = 2;
  localparam int unsigned LAT1  = 1;

  logic clk = 1'b0;
  logic reset;
  logic [NI-1:0] if_req, dm_req, dm_we, if_valid, dm_valid, mem_en, mem_we, stall;
  logic [AW-1:0] if_addr [NI];
  logic [AW-1:0] dm_addr [NI];
  logic [AW-1:0] mem_addr [NI];
  logic [DW-1:0] dm_wdata [NI];
  logic [DW-1:0] if_rdata [NI];
  logic [DW-1:0] dm_rdata [NI];
  logic [DW-1:0] mem_wdata [NI];
  logic [DW-1:0] mem_rdata [NI];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT0), .STARVE_MAX(SMAX)) u_dut0 (
    .clk(clk), .reset(reset),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_valid(if_valid[0]),
    .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
    .dm_rdata(dm_rdata[0]), .dm_valid(dm_valid[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .stall(stall[0])
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT1), .STARVE_MAX(SMAX)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_valid(if_valid[1]),
    .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
    .dm_rdata(dm_rdata[1]), .dm_valid(dm_valid[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .stall(stall[1])
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  function automatic int unsigned lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  // Single comparison point
  task automatic chk(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cyc=%0d got=%h exp=%h", tag, i, cyc, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory macro: read data appears exactly MEM_LAT cycles after mem_en
  logic [DW-1:0] macro_mem [NI][WORDS];
  logic [DW-1:0] ref_mem   [NI][WORDS];
  bit            pend [NI];
  int            age  [NI];
  logic [5:0]    paddr [NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (mem_en[i] === 1'b1) begin
        if (mem_we[i] === 1'b1) begin
          macro_mem[i][mem_addr[i][7:2]] = mem_wdata[i];
          pend[i] = 1'b0;
        end else begin
          pend[i]  = 1'b1;
          age[i]   = 0;
          paddr[i] = mem_addr[i][7:2];
        end
      end else if (pend[i]) begin
        age[i]++;
      end
      if (pend[i] && age[i] == int'(lat_of(i))) begin
        mem_rdata[i] = macro_mem[i][paddr[i]];
        pend[i] = 1'b0;
      end else begin
        mem_rdata[i] = $urandom;
      end
    end
  end

  // Reference model: each granted access occupies cycles grant+1 .. grant+2+MEM_LAT
  bit            armed = 1'b0;
  bit            busy [NI];
  bit            win_dm [NI];
  bit            x_we [NI];
  int            issue_c [NI];
  int            done_c [NI];
  int            starve [NI];
  logic [31:0]   x_addr [NI];
  logic [31:0]   x_wdata [NI];
  logic [31:0]   x_data [NI];
  logic [31:0]   x_ifr [NI];
  logic [31:0]   x_dmr [NI];
  bit            ifv_seen [NI];
  bit            dmv_seen [NI];
  int            if_start [NI];
  int            dm_start [NI];
  int            if_lat [NI];
  int            dm_lat [NI];
  logic [15:0]   order_bits [NI];
  int            order_n [NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      bit e_en, e_ifv, e_dmv;
      int lat;
      lat = int'(lat_of(i));
      if (armed) begin
        e_en  = busy[i] && cyc == issue_c[i];
        e_ifv = busy[i] && cyc == done_c[i] && !win_dm[i];
        e_dmv = busy[i] && cyc == done_c[i] && win_dm[i];
        if (e_ifv) x_ifr[i] = x_data[i];
        if (e_dmv && !x_we[i]) x_dmr[i] = x_data[i];
        chk("mem_en", i, 32'(mem_en[i]), 32'(e_en));
        chk("if_valid", i, 32'(if_valid[i]), 32'(e_ifv));
        chk("dm_valid", i, 32'(dm_valid[i]), 32'(e_dmv));
        chk("if_rdata", i, if_rdata[i], x_ifr[i]);
        chk("dm_rdata", i, dm_rdata[i], x_dmr[i]);
        chk("stall", i, 32'(stall[i]), 32'((if_req[i] & ~e_ifv) | (dm_req[i] & ~e_dmv)));
        if (e_en) begin
          chk("mem_we", i, 32'(mem_we[i]), 32'(x_we[i]));
          if (x_we[i]) chk("mem_wdata", i, mem_wdata[i], x_wdata[i]);
        end
        if (busy[i] && cyc >= issue_c[i] && cyc < done_c[i]) chk("mem_addr", i, mem_addr[i], x_addr[i]);
        if (if_valid[i] === 1'b1) begin
          if_lat[i] = cyc - if_start[i];
          if (order_n[i] < 16) begin order_bits[i][order_n[i]] = 1'b0; order_n[i]++; end
        end
        if (dm_valid[i] === 1'b1) begin
          dm_lat[i] = cyc - dm_start[i];
          if (order_n[i] < 16) begin order_bits[i][order_n[i]] = 1'b1; order_n[i]++; end
        end
      end
      ifv_seen[i] = (if_valid[i] === 1'b1);
      dmv_seen[i] = (dm_valid[i] === 1'b1);
      if (reset) begin
        busy[i] = 1'b0; starve[i] = 0; x_ifr[i] = '0; x_dmr[i] = '0;
      end else if (armed) begin
        if (busy[i] && cyc == done_c[i]) begin
          busy[i] = 1'b0;
        end else if (!busy[i] && (if_req[i] || dm_req[i])) begin
          win_dm[i] = dm_req[i] && !(if_req[i] && starve[i] == int'(SMAX));
          if (win_dm[i] && if_req[i]) starve[i] = (starve[i] < int'(SMAX)) ? starve[i] + 1 : starve[i];
          else starve[i] = 0;
          x_we[i]    = win_dm[i] && dm_we[i];
          x_addr[i]  = win_dm[i] ? dm_addr[i] : if_addr[i];
          x_wdata[i] = dm_wdata[i];
          if (x_we[i]) ref_mem[i][x_addr[i][7:2]] = x_wdata[i];
          else         x_data[i] = ref_mem[i][x_addr[i][7:2]];
          busy[i] = 1'b1; issue_c[i] = cyc + 1; done_c[i] = cyc + 2 + lat;
        end
      end
    end
    if (reset) armed = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic raise_if(input int i, input logic [31:0] a);
    if_req[i] = 1'b1; if_addr[i] = a; if_start[i] = cyc;
  endtask

  task automatic raise_dm(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
    dm_req[i] = 1'b1; dm_we[i] = we; dm_addr[i] = a; dm_wdata[i] = d; dm_start[i] = cyc;
  endtask

  // Release each request after its completion; bounded wait
  task automatic drain(input int budget);
    for (int n = 0; n < budget; n++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        if (ifv_seen[i]) if_req[i] = 1'b0;
        if (dmv_seen[i]) dm_req[i] = 1'b0;
      end
      if (if_req == '0 && dm_req == '0) break;
    end
    chk("drain_timeout", 0, 32'({if_req, dm_req}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    reset = 1'b1; if_req = '0; dm_req = '0; dm_we = '0;
    for (int i = 0; i < NI; i++) begin
      if_addr[i] = '0; dm_addr[i] = '0; dm_wdata[i] = '0; order_n[i] = 0; order_bits[i] = '0;
      for (int w = 0; w < int'(WORDS); w++) begin
        v = $urandom; macro_mem[i][w] = v; ref_mem[i][w] = v;
      end
      macro_mem[i][4]  = 32'h0050_0093; ref_mem[i][4]  = 32'h0050_0093;
      macro_mem[i][16] = 32'hDEAD_BEEF; ref_mem[i][16] = 32'hDEAD_BEEF;
    end
    tick(); tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_mem_en", i, 32'(mem_en[i]), 32'd0);
      chk("rst_if_rdata", i, if_rdata[i], 32'd0);
    end
    tick();

    // Single fetch
    for (int i = 0; i < NI; i++) raise_if(i, 32'h10);
    drain(40);
    for (int i = 0; i < NI; i++) begin
      chk("t1_lat", i, 32'(if_lat[i]), 32'(2 + lat_of(i)));
      chk("t1_data", i, if_rdata[i], 32'h0050_0093);
    end
    tick();

    // Simultaneous fetch and load: load first, fetch after one full access slot
    for (int i = 0; i < NI; i++) begin
      raise_if(i, 32'h20);
      raise_dm(i, 1'b0, 32'h40, 32'h0);
    end
    drain(60);
    for (int i = 0; i < NI; i++) begin
      chk("t2_dm_lat", i, 32'(dm_lat[i]), 32'(2 + lat_of(i)));
      chk("t2_if_lat", i, 32'(if_lat[i]), 32'(2 * lat_of(i) + 5));
      chk("t2_dm_data", i, dm_rdata[i], 32'hDEAD_BEEF);
    end
    tick();

    // Starvation guard: both held, grant order D,D,D,D,I,D
    for (int i = 0; i < NI; i++) begin
      order_n[i] = 0; order_bits[i] = '0;
      raise_if(i, 32'h24);
      raise_dm(i, 1'b0, 32'h44, 32'h0);
    end
    for (int n = 0; n < 200; n++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        if (ifv_seen[i] && order_n[i] >= 6) if_req[i] = 1'b0;
        if (dmv_seen[i] && order_n[i] >= 6) dm_req[i] = 1'b0;
      end
      if (if_req == '0 && dm_req == '0) break;
    end
    for (int i = 0; i < NI; i++) chk("t3_order", i, 32'(order_bits[i][5:0]), 32'h2F);
    tick();

    // Store: no effect on dm_rdata, memory written
    for (int i = 0; i < NI; i++) raise_dm(i, 1'b1, 32'h80, 32'h1234_5678);
    drain(40);
    for (int i = 0; i < NI; i++) begin
      chk("t4_lat", i, 32'(dm_lat[i]), 32'(2 + lat_of(i)));
      chk("t4_rdata_kept", i, dm_rdata[i], ref_mem[i][17]);
      chk("t4_mem", i, macro_mem[i][32], 32'h1234_5678);
    end
    for (int i = 0; i < NI; i++) dm_we[i] = 1'b0;
    tick();

    // Reset in the middle of an access
    for (int i = 0; i < NI; i++) raise_if(i, 32'h14);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; if_req = '0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("t5_no_valid", i, 32'(if_valid[i]), 32'd0);
      chk("t5_no_en", i, 32'(mem_en[i]), 32'd0);
    end
    tick();
    for (int i = 0; i < NI; i++) raise_if(i, 32'h18);
    drain(40);
    for (int i = 0; i < NI; i++) chk("t5_lat", i, 32'(if_lat[i]), 32'(2 + lat_of(i)));

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      tick();
      reset = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < NI; i++) begin
        if (if_req[i] && ifv_seen[i]) begin
          if ($urandom_range(0, 1) == 0) if_req[i] = 1'b0;
          else raise_if(i, {24'h0, 4'($urandom_range(0, 15)), 4'h0} >> 2);
        end else if (!if_req[i] && $urandom_range(0, 2) == 0) begin
          raise_if(i, 32'({$urandom_range(0, 15), 2'b00}));
        end
        if (dm_req[i] && dmv_seen[i]) begin
          if ($urandom_range(0, 1) == 0) dm_req[i] = 1'b0;
          else raise_dm(i, ($urandom_range(0, 2) == 0), 32'({$urandom_range(0, 15), 2'b00}), $urandom);
        end else if (!dm_req[i] && $urandom_range(0, 2) == 0) begin
          raise_dm(i, ($urandom_range(0, 2) == 0), 32'({$urandom_range(0, 15), 2'b00}), $urandom);
        end
      end
    end
    reset = 1'b0;
    drain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
